// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: address field layout, write-path FSM encodings
// and the command constants the engine drives onto the bus.
package sdram_pkg;

  localparam int BANK_W     = 2;
  localparam int ROW_W      = 13;
  localparam int COL_W      = 9;
  localparam int ADDR_W     = BANK_W + ROW_W + COL_W;
  localparam int MAX_COLUMN = 512;

  // One-hot write-request FSM states
  localparam logic [3:0] ST_IDLE  = 4'b0001;
  localparam logic [3:0] ST_REQ   = 4'b0010;
  localparam logic [3:0] ST_BURST = 4'b0100;
  localparam logic [3:0] ST_CHECK = 4'b1000;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_INHIBIT   = 4'b1111;
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;
  localparam logic [3:0] CMD_BURST_TRM = 4'b0110;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REF  = 4'b0001;
  localparam logic [3:0] CMD_LOAD_MODE = 4'b0000;

  function automatic logic [COL_W-1:0] addr_col(input logic [ADDR_W-1:0] a);
    return a[COL_W-1:0];
  endfunction

  function automatic logic [ROW_W-1:0] addr_row(input logic [ADDR_W-1:0] a);
    return a[COL_W +: ROW_W];
  endfunction

  function automatic logic [BANK_W-1:0] addr_bank(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: BANK_W];
  endfunction

endpackage

// File: rtl/sdram_wfifo_burst_ctrl.sv
// Write-side burst controller: waits for a full burst in the user FIFO, issues
// one write request, streams FIFO words on each engine ack, re-issues truncated tails.
//
// state | meaning
// IDLE  | waiting for FIFO level >= burst length
// REQ   | wr_en held until the engine takes the first word
// BURST | streaming words on wr_ack until wr_end
// CHECK | re-issue remainder after truncation, or advance/wrap and finish
module sdram_wfifo_burst_ctrl
  import sdram_pkg::*;
#(
  parameter logic [23:0] WR_BASE_ADDR = 24'd0,
  parameter logic [23:0] WR_END_ADDR  = 24'd1024,
  parameter logic [9:0]  WR_BURST_LEN = 10'd64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        addr_rst,
  input  logic [9:0]  wfifo_usedw,
  input  logic [15:0] wfifo_q,
  output logic        wfifo_rd_en,
  output logic        wr_en,
  output logic [23:0] wr_addr,
  output logic [9:0]  wr_burst_len,
  output logic [15:0] wr_data,
  input  logic        wr_ack,
  input  logic        wr_end,
  output logic        busy
);

  logic [3:0]  state_q, state_d;
  logic [23:0] wr_addr_q, wr_addr_d;
  logic [9:0]  wr_burst_len_q, wr_burst_len_d;
  logic [23:0] cur_addr_q, cur_addr_d;
  logic [9:0]  ack_cnt_q, ack_cnt_d;
  logic        busy_q, busy_d;
  logic        rst_pend_q, rst_pend_d;
  logic [9:0]  rem;
  logic        in_xfer;

  assign rem     = wr_burst_len_q - ack_cnt_q;
  assign in_xfer = (state_q == ST_REQ) || (state_q == ST_BURST);

  always_comb begin
    state_d        = state_q;
    wr_addr_d      = wr_addr_q;
    wr_burst_len_d = wr_burst_len_q;
    cur_addr_d     = cur_addr_q;
    ack_cnt_d      = ack_cnt_q;
    busy_d         = busy_q;
    rst_pend_d     = rst_pend_q;

    case (state_q)
      ST_IDLE: begin
        if (addr_rst) begin
          cur_addr_d = WR_BASE_ADDR;
          wr_addr_d  = WR_BASE_ADDR;
          rst_pend_d = 1'b0;
        end
        if (wfifo_usedw >= WR_BURST_LEN) begin
          state_d        = ST_REQ;
          wr_addr_d      = addr_rst ? WR_BASE_ADDR : cur_addr_q;
          wr_burst_len_d = WR_BURST_LEN;
          ack_cnt_d      = '0;
          busy_d         = 1'b1;
        end
      end

      ST_REQ, ST_BURST: begin
        if (addr_rst) rst_pend_d = 1'b1;
        if (wr_ack) begin
          ack_cnt_d  = ack_cnt_q + 10'd1;
          cur_addr_d = cur_addr_q + 24'd1;
          state_d    = ST_BURST;
        end
        // An early wr_end (even with no ack) still goes through CHECK so the
        // unserved remainder is re-requested.
        if (wr_end) state_d = ST_CHECK;
      end

      ST_CHECK: begin
        if (rem != 10'd0) begin
          if (addr_rst) rst_pend_d = 1'b1;
          wr_addr_d      = cur_addr_q;
          wr_burst_len_d = rem;
          ack_cnt_d      = '0;
          state_d        = ST_REQ;
        end else begin
          if (rst_pend_q || addr_rst) begin
            cur_addr_d = WR_BASE_ADDR;
            rst_pend_d = 1'b0;
          end else if (cur_addr_q >= WR_END_ADDR) begin
            cur_addr_d = WR_BASE_ADDR;
          end
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      wr_addr_q      <= WR_BASE_ADDR;
      wr_burst_len_q <= WR_BURST_LEN;
      cur_addr_q     <= WR_BASE_ADDR;
      ack_cnt_q      <= '0;
      busy_q         <= 1'b0;
      rst_pend_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_addr_q      <= wr_addr_d;
      wr_burst_len_q <= wr_burst_len_d;
      cur_addr_q     <= cur_addr_d;
      ack_cnt_q      <= ack_cnt_d;
      busy_q         <= busy_d;
      rst_pend_q     <= rst_pend_d;
    end
  end

  // FIFO is in normal (non-showahead) mode, so the word lands on wfifo_q one
  // cycle after the ack, lining up with the engine's registered data enable.
  assign wfifo_rd_en  = wr_ack && in_xfer;
  assign wr_en        = (state_q == ST_REQ);
  assign wr_addr      = wr_addr_q;
  assign wr_burst_len = wr_burst_len_q;
  assign wr_data      = wfifo_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_sdram_wfifo_burst_ctrl.sv
// Scoreboard bench: three controllers (default region, base 480, end 128) driven
// by a directed engine model; a monitor checks every issued request against a queue.
module tb_sdram_wfifo_burst_ctrl;

  typedef struct {
    int          idx;
    logic [23:0] addr;
    logic [9:0]  len;
  } req_t;

  logic        clk;
  logic        rst_n;
  logic        addr_rst    [3];
  logic [9:0]  usedw       [3];
  logic [15:0] fifo_q      [3];
  logic        rd_en       [3];
  logic        wr_en       [3];
  logic [23:0] wr_addr     [3];
  logic [9:0]  wr_len      [3];
  logic [15:0] wr_data     [3];
  logic        wr_ack      [3];
  logic        wr_end      [3];
  logic        busy        [3];

  int   total = 0;
  int   bad   = 0;
  int   rd_cnt [3];
  logic wr_en_prev [3];
  req_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sdram_wfifo_burst_ctrl u_def (
    .clk(clk), .rst_n(rst_n), .addr_rst(addr_rst[0]), .wfifo_usedw(usedw[0]),
    .wfifo_q(fifo_q[0]), .wfifo_rd_en(rd_en[0]), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]),
    .wr_burst_len(wr_len[0]), .wr_data(wr_data[0]), .wr_ack(wr_ack[0]),
    .wr_end(wr_end[0]), .busy(busy[0]));

  sdram_wfifo_burst_ctrl #(.WR_BASE_ADDR(24'd480), .WR_END_ADDR(24'd1056)) u_row (
    .clk(clk), .rst_n(rst_n), .addr_rst(addr_rst[1]), .wfifo_usedw(usedw[1]),
    .wfifo_q(fifo_q[1]), .wfifo_rd_en(rd_en[1]), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]),
    .wr_burst_len(wr_len[1]), .wr_data(wr_data[1]), .wr_ack(wr_ack[1]),
    .wr_end(wr_end[1]), .busy(busy[1]));

  sdram_wfifo_burst_ctrl #(.WR_END_ADDR(24'd128)) u_wrap (
    .clk(clk), .rst_n(rst_n), .addr_rst(addr_rst[2]), .wfifo_usedw(usedw[2]),
    .wfifo_q(fifo_q[2]), .wfifo_rd_en(rd_en[2]), .wr_en(wr_en[2]), .wr_addr(wr_addr[2]),
    .wr_burst_len(wr_len[2]), .wr_data(wr_data[2]), .wr_ack(wr_ack[2]),
    .wr_end(wr_end[2]), .busy(busy[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic req_t mk(input int i, input logic [23:0] a, input logic [9:0] l);
    req_t r;
    r.idx = i; r.addr = a; r.len = l;
    return r;
  endfunction

  // Monitor: every rising wr_en must match the next queued request
  initial begin
    for (int i = 0; i < 3; i++) begin rd_cnt[i] = 0; wr_en_prev[i] = 1'b0; end
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int i = 0; i < 3; i++) begin
          if (wr_en[i] && !wr_en_prev[i]) begin
            if (exp_q.size() == 0) begin
              total++; bad++;
              $display("FAIL unexpected_req: inst %0d addr %0d len %0d, none expected",
                       i, wr_addr[i], wr_len[i]);
            end else begin
              req_t r;
              r = exp_q.pop_front();
              chk("req_inst", i, r.idx);
              chk("req_addr", wr_addr[i], r.addr);
              chk("req_len", wr_len[i], r.len);
              chk("req_busy", busy[i], 1);
            end
          end
          if (rd_en[i]) begin
            rd_cnt[i]++;
            chk("rd_en_needs_ack", wr_ack[i], 1);
          end
        end
      end
      for (int i = 0; i < 3; i++) wr_en_prev[i] = wr_en[i];
    end
  end

  // Engine model: wait for the request, ack n words, then pulse wr_end.
  task automatic burst(input int i, input int n, input int rst_at);
    int cnt0;
    int waited;
    usedw[i] = 10'd64;
    waited = 0;
    while (!wr_en[i] && waited < 100) begin step(); waited++; end
    if (!wr_en[i]) begin
      total++; bad++;
      $display("FAIL req_timeout: inst %0d wr_en got 0 expected 1", i);
      usedw[i] = 10'd0;
      return;
    end
    cnt0 = rd_cnt[i];
    for (int k = 0; k < n; k++) begin
      wr_ack[i] = 1'b1;
      if (k == 0) usedw[i] = 10'd0;
      if (k == rst_at) addr_rst[i] = 1'b1;
      step();
      addr_rst[i] = 1'b0;
      if (k == 0) chk("wr_en_after_ack", wr_en[i], 0);
    end
    wr_ack[i] = 1'b0;
    usedw[i]  = 10'd0;
    wr_end[i] = 1'b1;
    step();
    wr_end[i] = 1'b0;
    chk("rd_en_count", rd_cnt[i] - cnt0, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr_rst[i] = 1'b0; usedw[i] = 10'd0; fifo_q[i] = 16'h1234 + 16'(i);
      wr_ack[i] = 1'b0; wr_end[i] = 1'b0;
    end
    step(); step(); step();

    chk("rst_wr_en", wr_en[0], 0);
    chk("rst_rd_en", rd_en[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_addr0", wr_addr[0], 0);
    chk("rst_len0", wr_len[0], 64);
    chk("rst_addr1", wr_addr[1], 480);
    chk("wr_data_pass", wr_data[1], 16'h1235);
    rst_n = 1'b1;
    step();

    // Threshold: 63 words never triggers
    usedw[0] = 10'd63;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("below_threshold", wr_en[0], 0);
    end
    exp_q.push_back(mk(0, 24'd0, 10'd64));
    usedw[0] = 10'd64;
    step();
    chk("wr_en_next_cycle", wr_en[0], 1);
    burst(0, 64, -1);
    chk("busy_in_check", busy[0], 1);
    step();
    chk("busy_cleared", busy[0], 0);

    // addr_rst mid-burst: burst completes, next request returns to base
    exp_q.push_back(mk(0, 24'd64, 10'd64));
    burst(0, 64, 10);
    exp_q.push_back(mk(0, 24'd0, 10'd64));
    burst(0, 64, -1);

    // addr_rst while idle
    step();
    addr_rst[0] = 1'b1;
    step();
    addr_rst[0] = 1'b0;
    chk("idle_addr_rst", wr_addr[0], 0);
    exp_q.push_back(mk(0, 24'd0, 10'd64));
    burst(0, 64, -1);

    // Stray acks while idle are ignored
    step();
    wr_ack[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stray_ack_rd_en", rd_en[0], 0);
      step();
      chk("stray_ack_busy", busy[0], 0);
    end
    wr_ack[0] = 1'b0;

    // wr_end without any ack re-issues the full request at the same address
    exp_q.push_back(mk(0, 24'd64, 10'd64));
    exp_q.push_back(mk(0, 24'd64, 10'd64));
    burst(0, 0, -1);
    burst(0, 64, -1);

    // Row split at 512
    exp_q.push_back(mk(1, 24'd480, 10'd64));
    exp_q.push_back(mk(1, 24'd512, 10'd32));
    burst(1, 32, -1);
    chk("row_split_busy", busy[1], 1);
    burst(1, 32, -1);
    chk("row_split_busy_end", busy[1], 1);
    step();
    chk("row_split_done", busy[1], 0);

    // Wrap at END=128
    exp_q.push_back(mk(2, 24'd0, 10'd64));
    exp_q.push_back(mk(2, 24'd64, 10'd64));
    exp_q.push_back(mk(2, 24'd0, 10'd64));
    burst(2, 64, -1);
    burst(2, 64, -1);
    burst(2, 64, -1);
    step();

    // Async reset in the middle of a burst at address 128
    exp_q.push_back(mk(0, 24'd128, 10'd64));
    usedw[0] = 10'd64;
    waited = 0;
    while (!wr_en[0] && waited < 100) begin step(); waited++; end
    chk("pre_reset_req", wr_en[0], 1);
    wr_ack[0] = 1'b1;
    usedw[0] = 10'd0;
    for (int c = 0; c < 5; c++) step();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy[0], 0);
    chk("async_rst_rd_en", rd_en[0], 0);
    chk("async_rst_addr", wr_addr[0], 0);
    wr_ack[0] = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    exp_q.push_back(mk(0, 24'd0, 10'd64));
    burst(0, 64, -1);
    step();

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_wfifo_burst_ctrl.md
Name: sdram_wfifo_burst_ctrl

Overview:
- Sits directly upstream of the SDRAM write engine, between the user write FIFO and the write-request path.
- Watches the FIFO fill level and issues one fixed-length write request once a full burst is buffered.
- Streams FIFO data out in lock-step with the engine's per-word acknowledge.
- Re-issues the remainder when the engine truncates a burst at a row end, then advances and wraps the SDRAM write address.

Parameters:
- WR_BASE_ADDR, 24'd0, first word address of write region ({bank[1:0],row[12:0],col[8:0]}).
- WR_END_ADDR, 24'd1024, one past last word of region; (END-BASE) is a multiple of WR_BURST_LEN.
- WR_BURST_LEN, 10'd64, words per request, 1..512.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- addr_rst  in  1  one-cycle pulse; return write pointer to WR_BASE_ADDR
- wfifo_usedw  in  10  write FIFO fill count
- wfifo_q  in  16  FIFO read data; normal mode, valid the cycle after rd_en
- wfifo_rd_en  out  1  FIFO read strobe
- wr_en  out  1  write request to engine (level)
- wr_addr  out  24  start word address of current request
- wr_burst_len  out  10  words requested
- wr_data  out  16  data to engine (= wfifo_q, combinational)
- wr_ack  in  1  engine accepts one word this cycle
- wr_end  in  1  engine finished request (one-cycle pulse)
- busy  out  1  high from request issue until final wr_end of the burst

Behaviour:
- Reset rst_n is asynchronous, active-low; clock is clk.
- Reset values: wr_en=0, wr_addr=WR_BASE_ADDR, wr_burst_len=WR_BURST_LEN, wfifo_rd_en=0, busy=0, internal cur_addr=WR_BASE_ADDR, ack_cnt=0.
- State IDLE:
  - Goes to REQ when wfifo_usedw >= WR_BURST_LEN.
  - On entry to REQ: wr_addr<=cur_addr, wr_burst_len<=WR_BURST_LEN, ack_cnt<=0, busy<=1.
- State REQ:
  - wr_en=1, held until the first wr_ack, then goes to BURST.
  - wr_en deasserts combinationally-registered: low from the cycle after the first wr_ack.
- State BURST:
  - wr_en=0.
  - Each wr_ack increments ack_cnt and cur_addr by 1.
  - On wr_end, goes to CHECK.
- wfifo_rd_en = wr_ack while in REQ or BURST, else 0.
  - The FIFO word therefore appears on wfifo_q one cycle after the ack, matching the engine's registered data-enable.
  - wr_data = wfifo_q unconditionally.
- State CHECK (1 cycle):
  - rem = wr_burst_len - ack_cnt.
  - If rem != 0 (row-end truncation): wr_addr<=cur_addr, wr_burst_len<=rem, ack_cnt<=0, go to REQ. The FIFO level is not rechecked.
  - If rem == 0: when cur_addr >= WR_END_ADDR, set cur_addr<=WR_BASE_ADDR. Then busy<=0 and go to IDLE.
- cur_addr arithmetic is 24-bit unsigned. Column carry naturally rolls into the row field.
- addr_rst:
  - In IDLE, takes effect next cycle (cur_addr and wr_addr <= WR_BASE_ADDR).
  - During REQ/BURST/CHECK, a pending flag is latched and applied in CHECK after rem==0, overriding wrap. A burst is never aborted.
- wr_ack without a prior wr_en (engine protocol error): ignored in IDLE; wfifo_rd_en stays 0.
- wr_end with ack_cnt==0: rem = full length, request re-issued at the same address.
- Async reset mid-burst: everything returns to reset values. FIFO contents are not restored.

Decomposition:
- Shared package sdram_pkg holds:
  - address field widths (BANK_W=2, ROW_W=13, COL_W=9) and MAX_COLUMN=512;
  - state encodings IDLE/REQ/BURST/CHECK as one-hot localparams;
  - SDRAM command constants reused by the engine.
- No sub-module; single flat FSM plus counters.

Test Plan:
- Reset: hold rst_n=0 -> wr_en=0, wfifo_rd_en=0, busy=0, wr_addr=0, wr_burst_len=64.
- Threshold: usedw=63 for 20 cycles -> wr_en stays 0. usedw=64 -> wr_en=1 next cycle, wr_addr=0, wr_burst_len=64.
- Full burst: engine model acks 64 consecutive cycles then pulses wr_end -> wfifo_rd_en high exactly 64 cycles aligned with wr_ack; wr_en low after first ack; next request wr_addr=64.
- Row split: WR_BASE_ADDR=480, engine acks 32 then wr_end -> CHECK re-issues wr_en with wr_addr=512 (row+1, col 0) and wr_burst_len=32; busy stays high across both.
- Wrap: WR_END_ADDR=128, three 64-word bursts -> wr_addr sequence 0, 64, 0.
- addr_rst pulsed mid-BURST at cur_addr=64 -> burst completes (64 acks), next request wr_addr=0 rather than 128.
